// File: rtl/codedlock_ctrl_if.sv
// -----------------------------------------------------------------------------
// codedlock_ctrl_if
// Lock-panel signal bundle between the coded-lock sequencer and its panel.
//   code_in     panel -> ctrl  code switches {q,u,n,b}, asynchronous
//   key_ok_n    panel -> ctrl  confirm key, active-low, asynchronous
//   key_chg_n   panel -> ctrl  change-code key, active-low, asynchronous
//   led_red_n   ctrl -> panel  red LED, active-low
//   led_green_n ctrl -> panel  green LED, active-low
//   unlocked    ctrl -> panel  high while the lock is open
//   fail_pulse  ctrl -> panel  1-cycle pulse on every rejected code
//   chg_done    ctrl -> panel  1-cycle pulse when a new code is committed
// master = panel side (drives switches/keys), slave = controller side.
// -----------------------------------------------------------------------------
interface codedlock_ctrl_if #(
  parameter int unsigned CODE_W = 4
);
  logic [CODE_W-1:0] code_in;
  logic              key_ok_n;
  logic              key_chg_n;
  logic              led_red_n;
  logic              led_green_n;
  logic              unlocked;
  logic              fail_pulse;
  logic              chg_done;

  modport master (
    output code_in, key_ok_n, key_chg_n,
    input  led_red_n, led_green_n, unlocked, fail_pulse, chg_done
  );

  modport slave (
    input  code_in, key_ok_n, key_chg_n,
    output led_red_n, led_green_n, unlocked, fail_pulse, chg_done
  );
endinterface

// File: rtl/codedlock_ctrl.sv
// -----------------------------------------------------------------------------
// codedlock_ctrl
// Clocked sequencer for a 4-switch coded lock: synchronises the code switches
// and the active-low keys, then runs unlock, change-code and lockout. Holds the
// stored code, counts consecutive failed attempts and times the open/lockout
// windows and the change-code inactivity timeout.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active-low (code reverts to INIT_CODE)
//   pnl    codedlock_ctrl_if.slave: code_in/key_ok_n/key_chg_n in,
//          led_red_n/led_green_n/unlocked/fail_pulse/chg_done out
// -----------------------------------------------------------------------------
module codedlock_ctrl #(
  parameter int unsigned          CODE_W      = 4,
  parameter logic [CODE_W-1:0]    INIT_CODE   = {CODE_W{1'b1}},
  parameter int unsigned          MAX_FAIL    = 3,
  parameter int unsigned          OPEN_CYCLES = 100,
  parameter int unsigned          LOCK_CYCLES = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  codedlock_ctrl_if.slave  pnl
);

  localparam int unsigned       FCNT_W     = $clog2(MAX_FAIL + 1);
  localparam logic [FCNT_W-1:0] FAIL_LIMIT = FCNT_W'(MAX_FAIL);
  localparam logic [31:0]       OPEN_LOAD  = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0]       LOCK_LOAD  = 32'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CHG_OLD = 3'd2,
    ST_CHG_NEW = 3'd3,
    ST_CHG_CFM = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  // Input synchronisers and key edge history
  logic [CODE_W-1:0] code_s1_q, code_s2_q;
  logic              ok_s1_q, ok_s2_q, ok_prev_q;
  logic              chg_s1_q, chg_s2_q, chg_prev_q;
  logic              ok_p_s, chg_p_s;

  // Sequencer state
  state_t            state_q, state_d;
  logic [CODE_W-1:0] stored_q, stored_d;
  logic [CODE_W-1:0] new_code_q, new_code_d;
  logic [FCNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [FCNT_W-1:0] fail_inc_s;
  logic [31:0]       timer_q, timer_d;
  logic              code_match_s;

  // Registered outputs
  logic red_n_q, red_n_d;
  logic green_n_q, green_n_d;
  logic unlocked_q, unlocked_d;
  logic fail_q, fail_d;
  logic done_q, done_d;
  logic red_on_s, green_on_s;

  // Two-flop synchronisers plus one extra key stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_s1_q  <= {CODE_W{1'b0}};
      code_s2_q  <= {CODE_W{1'b0}};
      ok_s1_q    <= 1'b1;
      ok_s2_q    <= 1'b1;
      ok_prev_q  <= 1'b1;
      chg_s1_q   <= 1'b1;
      chg_s2_q   <= 1'b1;
      chg_prev_q <= 1'b1;
    end else begin
      code_s1_q  <= pnl.code_in;
      code_s2_q  <= code_s1_q;
      ok_s1_q    <= pnl.key_ok_n;
      ok_s2_q    <= ok_s1_q;
      ok_prev_q  <= ok_s2_q;
      chg_s1_q   <= pnl.key_chg_n;
      chg_s2_q   <= chg_s1_q;
      chg_prev_q <= chg_s2_q;
    end
  end

  // A press is the 1->0 edge of the synchronised key, so a held key counts once
  assign ok_p_s       = ok_prev_q & ~ok_s2_q;
  assign chg_p_s      = chg_prev_q & ~chg_s2_q;
  assign code_match_s = (code_s2_q == stored_q);
  // Saturating increment: the count never wraps back to zero
  assign fail_inc_s   = (fail_cnt_q == FAIL_LIMIT) ? fail_cnt_q : (fail_cnt_q + FCNT_W'(1));

  // Next-state, datapath updates and output decode from the next state
  always_comb begin
    state_d    = state_q;
    stored_d   = stored_q;
    new_code_d = new_code_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    fail_d     = 1'b0;
    done_d     = 1'b0;
    red_on_s   = 1'b0;
    green_on_s = 1'b0;
    unlocked_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // chg_p has priority over a simultaneous ok_p
        if (chg_p_s) begin
          state_d = ST_CHG_OLD;
          timer_d = OPEN_LOAD;
        end else if (ok_p_s) begin
          if (code_match_s) begin
            state_d    = ST_OPEN;
            timer_d    = OPEN_LOAD;
            fail_cnt_d = {FCNT_W{1'b0}};
          end else begin
            fail_d     = 1'b1;
            fail_cnt_d = fail_inc_s;
            if (fail_inc_s == FAIL_LIMIT) begin
              state_d = ST_LOCKOUT;
              timer_d = LOCK_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_OPEN: begin
        if (timer_q == 32'd0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      ST_CHG_OLD: begin
        if (chg_p_s) begin
          state_d = ST_IDLE;
        end else if (ok_p_s) begin
          if (code_match_s) begin
            state_d    = ST_CHG_NEW;
            timer_d    = OPEN_LOAD;
            fail_cnt_d = {FCNT_W{1'b0}};
          end else begin
            fail_d     = 1'b1;
            fail_cnt_d = fail_inc_s;
            if (fail_inc_s == FAIL_LIMIT) begin
              state_d = ST_LOCKOUT;
              timer_d = LOCK_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (timer_q == 32'd0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      ST_CHG_NEW: begin
        if (chg_p_s) begin
          state_d = ST_IDLE;
        end else if (ok_p_s) begin
          new_code_d = code_s2_q;
          state_d    = ST_CHG_CFM;
          timer_d    = OPEN_LOAD;
        end else if (timer_q == 32'd0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      ST_CHG_CFM: begin
        if (chg_p_s) begin
          state_d = ST_IDLE;
        end else if (ok_p_s) begin
          // A confirm mismatch flags a failure but does not count as an attempt
          if (code_s2_q == new_code_q) begin
            stored_d = new_code_q;
            done_d   = 1'b1;
          end else begin
            fail_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (timer_q == 32'd0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == 32'd0) begin
          state_d    = ST_IDLE;
          fail_cnt_d = {FCNT_W{1'b0}};
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = 32'd0;
      end
    endcase

    // Outputs follow the state being entered so they switch on the same edge
    case (state_d)
      ST_IDLE: begin
        red_on_s   = 1'b0;
        green_on_s = 1'b0;
      end
      ST_OPEN: begin
        green_on_s = 1'b1;
        unlocked_d = 1'b1;
      end
      ST_CHG_OLD, ST_CHG_NEW, ST_CHG_CFM: begin
        red_on_s   = 1'b1;
        green_on_s = 1'b1;
      end
      ST_LOCKOUT: begin
        red_on_s = 1'b1;
      end
      default: begin
        red_on_s   = 1'b0;
        green_on_s = 1'b0;
      end
    endcase

    // Red also flashes for the single cycle of every rejection
    red_n_d   = ~(red_on_s | fail_d);
    green_n_d = ~green_on_s;
  end

  // Sequencer state, stored code, failure counter and window timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      stored_q   <= INIT_CODE;
      new_code_q <= {CODE_W{1'b0}};
      fail_cnt_q <= {FCNT_W{1'b0}};
      timer_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      stored_q   <= stored_d;
      new_code_q <= new_code_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_n_q    <= 1'b1;
      green_n_q  <= 1'b1;
      unlocked_q <= 1'b0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      red_n_q    <= red_n_d;
      green_n_q  <= green_n_d;
      unlocked_q <= unlocked_d;
      fail_q     <= fail_d;
      done_q     <= done_d;
    end
  end

  assign pnl.led_red_n   = red_n_q;
  assign pnl.led_green_n = green_n_q;
  assign pnl.unlocked    = unlocked_q;
  assign pnl.fail_pulse  = fail_q;
  assign pnl.chg_done    = done_q;

endmodule

// File: tb/tb_codedlock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_codedlock_ctrl
// Directed bench for codedlock_ctrl (MAX_FAIL=3, OPEN_CYCLES=8, LOCK_CYCLES=16,
// INIT_CODE=F). A mode/cycles-left model predicts the panel outputs every cycle;
// literal counts of green/red/unlocked cycles and pulses pin the model.
// -----------------------------------------------------------------------------
module tb_codedlock_ctrl;

  localparam int MAXF  = 3;
  localparam int OPENC = 8;
  localparam int LOCKC = 16;

  localparam int M_IDLE = 0, M_OPEN = 1, M_OLD = 2, M_NEW = 3, M_CFM = 4, M_LOCK = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  codedlock_ctrl_if #(.CODE_W(4)) pnl ();

  codedlock_ctrl #(
    .CODE_W(4), .INIT_CODE(4'hF), .MAX_FAIL(MAXF),
    .OPEN_CYCLES(OPENC), .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pnl(pnl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode, m_left, m_fails;
  logic [3:0] m_stored, m_pending;
  logic       m_fail, m_done;
  logic       h_ok[3], h_chg[3];
  logic [3:0] h_code[3];
  logic       okp, chgp;
  logic [3:0] pc;

  task automatic reject();
    m_fail = 1'b1;
    if (m_fails < MAXF) m_fails++;
    if (m_fails == MAXF) begin
      m_mode = M_LOCK;
      m_left = LOCKC;
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_left = 0; m_fails = 0;
      m_stored = 4'hF; m_pending = 4'h0; m_fail = 1'b0; m_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
        h_ok[i] = 1'b1; h_chg[i] = 1'b1; h_code[i] = 4'h0;
      end
    end else begin
      // pin level seen three edges ago high, two edges ago low => press now
      okp  = h_ok[2] & ~h_ok[1];
      chgp = h_chg[2] & ~h_chg[1];
      pc   = h_code[1];
      h_ok[2] = h_ok[1];   h_ok[1] = h_ok[0];   h_ok[0] = pnl.key_ok_n;
      h_chg[2] = h_chg[1]; h_chg[1] = h_chg[0]; h_chg[0] = pnl.key_chg_n;
      h_code[2] = h_code[1]; h_code[1] = h_code[0]; h_code[0] = pnl.code_in;
      m_fail = 1'b0; m_done = 1'b0;
      if (m_mode == M_IDLE) begin
        if (chgp) begin m_mode = M_OLD; m_left = OPENC; end
        else if (okp) begin
          if (pc == m_stored) begin m_mode = M_OPEN; m_left = OPENC; m_fails = 0; end
          else reject();
        end
      end else if (m_mode == M_OPEN || m_mode == M_LOCK) begin
        m_left--;
        if (m_left == 0) begin
          if (m_mode == M_LOCK) m_fails = 0;
          m_mode = M_IDLE;
        end
      end else begin
        if (chgp) m_mode = M_IDLE;
        else if (okp) begin
          if (m_mode == M_OLD) begin
            if (pc == m_stored) begin m_mode = M_NEW; m_left = OPENC; m_fails = 0; end
            else reject();
          end else if (m_mode == M_NEW) begin
            m_pending = pc; m_mode = M_CFM; m_left = OPENC;
          end else begin
            if (pc == m_pending) begin m_stored = m_pending; m_done = 1'b1; end
            else m_fail = 1'b1;
            m_mode = M_IDLE;
          end
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    end
  end

  // ---------------- compare process and activity counters ----------------
  int green_cyc = 0, red_cyc = 0, unl_cyc = 0, fail_seen = 0, done_seen = 0;
  logic chg_mode;

  always @(negedge clk) begin
    chg_mode = (m_mode == M_OLD) || (m_mode == M_NEW) || (m_mode == M_CFM);
    if (chk_en) begin
      check("unlocked",    {31'd0, pnl.unlocked},    {31'd0, m_mode == M_OPEN});
      check("led_green_n", {31'd0, pnl.led_green_n}, {31'd0, !(m_mode == M_OPEN || chg_mode)});
      check("led_red_n",   {31'd0, pnl.led_red_n},   {31'd0, !(m_mode == M_LOCK || chg_mode || m_fail)});
      check("fail_pulse",  {31'd0, pnl.fail_pulse},  {31'd0, m_fail});
      check("chg_done",    {31'd0, pnl.chg_done},    {31'd0, m_done});
    end
    if (pnl.led_green_n == 1'b0) green_cyc++;
    if (pnl.led_red_n == 1'b0)   red_cyc++;
    if (pnl.unlocked)            unl_cyc++;
    if (pnl.fail_pulse)          fail_seen++;
    if (pnl.chg_done)            done_seen++;
  end

  // ---------------- stimulus ----------------
  int b_green, b_red, b_unl, b_fail, b_done;

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic snap();
    settle();
    b_green = green_cyc; b_red = red_cyc; b_unl = unl_cyc;
    b_fail = fail_seen;  b_done = done_seen;
  endtask

  task automatic press(input logic ok, input logic chg, input logic [3:0] code, input int hold);
    @(negedge clk); pnl.code_in = code;
    @(negedge clk);
    if (ok)  pnl.key_ok_n  = 1'b0;
    if (chg) pnl.key_chg_n = 1'b0;
    repeat (hold) @(negedge clk);
    pnl.key_ok_n = 1'b1; pnl.key_chg_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pnl.code_in = 4'hF; pnl.key_ok_n = 1'b1; pnl.key_chg_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_red_n",    {31'd0, pnl.led_red_n},   32'd1);
    check("rst_green_n",  {31'd0, pnl.led_green_n}, 32'd1);
    check("rst_unlocked", {31'd0, pnl.unlocked},    32'd0);
    check("rst_fail",     {31'd0, pnl.fail_pulse},  32'd0);
    check("rst_done",     {31'd0, pnl.chg_done},    32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: correct code opens 3 clocks after the key edge, for exactly 8 cycles
    snap();
    pnl.key_ok_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_lat2_unlocked", {31'd0, pnl.unlocked}, 32'd0);
    @(negedge clk);
    check("t1_lat3_unlocked", {31'd0, pnl.unlocked},    32'd1);
    check("t1_lat3_green_n",  {31'd0, pnl.led_green_n}, 32'd0);
    pnl.key_ok_n = 1'b1;
    repeat (15) @(negedge clk);
    settle();
    check("t1_green_cycles", green_cyc - b_green, 32'd8);
    check("t1_unl_cycles",   unl_cyc - b_unl,     32'd8);
    check("t1_red_cycles",   red_cyc - b_red,     32'd0);

    // 2: three wrong codes -> lockout 16 cycles; a correct code inside it is ignored
    snap();
    press(1'b1, 1'b0, 4'h3, 2);
    press(1'b1, 1'b0, 4'h3, 2);
    settle();
    check("t2_two_fails", fail_seen - b_fail, 32'd2);
    b_red = red_cyc;
    press(1'b1, 1'b0, 4'h3, 2);
    press(1'b1, 1'b0, 4'hF, 2);
    repeat (25) @(negedge clk);
    settle();
    check("t2_fail_pulses",  fail_seen - b_fail, 32'd3);
    check("t2_lock_red_cyc", red_cyc - b_red,    32'd16);
    check("t2_unl_cycles",   unl_cyc - b_unl,    32'd0);

    // 3: change F -> A; old code then fails, new code opens
    snap();
    press(1'b0, 1'b1, 4'hF, 2);
    press(1'b1, 1'b0, 4'hF, 2);
    press(1'b1, 1'b0, 4'hA, 2);
    press(1'b1, 1'b0, 4'hA, 2);
    press(1'b1, 1'b0, 4'hF, 2);
    press(1'b1, 1'b0, 4'hA, 2);
    repeat (12) @(negedge clk);
    settle();
    check("t3_chg_done",  done_seen - b_done, 32'd1);
    check("t3_fail_once", fail_seen - b_fail, 32'd1);
    check("t3_unl_cyc",   unl_cyc - b_unl,    32'd8);

    // 4: confirm mismatch keeps F; a key held 50 cycles opens only once
    do_reset();
    snap();
    press(1'b0, 1'b1, 4'hF, 2);
    press(1'b1, 1'b0, 4'hF, 2);
    press(1'b1, 1'b0, 4'hA, 2);
    press(1'b1, 1'b0, 4'h5, 2);
    press(1'b1, 1'b0, 4'hF, 50);
    repeat (5) @(negedge clk);
    settle();
    check("t4_fail_once", fail_seen - b_fail, 32'd1);
    check("t4_no_done",   done_seen - b_done, 32'd0);
    check("t4_unl_cyc",   unl_cyc - b_unl,    32'd8);

    // 5: ok+chg together -> change mode; timeout in CHG_NEW leaves code unchanged
    snap();
    press(1'b1, 1'b1, 4'hF, 2);
    check("t5_both_red_n",   {31'd0, pnl.led_red_n},   32'd0);
    check("t5_both_green_n", {31'd0, pnl.led_green_n}, 32'd0);
    check("t5_not_open",     {31'd0, pnl.unlocked},    32'd0);
    press(1'b1, 1'b0, 4'hF, 2);
    repeat (20) @(negedge clk);
    check("t5_timeout_red_n", {31'd0, pnl.led_red_n}, 32'd1);
    press(1'b1, 1'b0, 4'hF, 2);
    repeat (12) @(negedge clk);
    settle();
    check("t5_unl_cyc", unl_cyc - b_unl,    32'd8);
    check("t5_no_fail", fail_seen - b_fail, 32'd0);

    // 6: asynchronous reset mid-CHG_CFM and mid-OPEN
    press(1'b0, 1'b1, 4'hF, 2);
    press(1'b1, 1'b0, 4'hF, 2);
    press(1'b1, 1'b0, 4'hA, 2);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    check("t6_cfm_rst_red_n",   {31'd0, pnl.led_red_n},   32'd1);
    check("t6_cfm_rst_green_n", {31'd0, pnl.led_green_n}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    press(1'b1, 1'b0, 4'hF, 2);
    check("t6_open_again", {31'd0, pnl.unlocked}, 32'd1);
    #2; rst_n = 1'b0; #1;
    check("t6_open_rst_unl",     {31'd0, pnl.unlocked},    32'd0);
    check("t6_open_rst_green_n", {31'd0, pnl.led_green_n}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap();
    press(1'b1, 1'b0, 4'hA, 2);
    repeat (4) @(negedge clk);
    settle();
    check("t6_A_rejected", fail_seen - b_fail, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
